// File: rtl/pipe_domain_sched_if.sv
// Bundle between the domain scheduler and the pipeline head.
// master: the scheduler side (drives domain, grant, drain, flush, slot_cnt).
// slave : the pipeline/requester side (drives enables, requests, head stall).
interface pipe_domain_sched_if #(
   parameter int CNT_W = 7
);
   logic [1:0]       dom_en;
   logic [1:0]       req_val;
   logic             head_stall;
   logic             domain;
   logic [1:0]       grant;
   logic             drain;
   logic             flush;
   logic [CNT_W-1:0] slot_cnt;

   modport master (
      input  dom_en, req_val, head_stall,
      output domain, grant, drain, flush, slot_cnt
   );

   modport slave (
      output dom_en, req_val, head_stall,
      input  domain, grant, drain, flush, slot_cnt
   );
endinterface

// File: rtl/pipe_domain_sched.sv
// Time-multiplexing scheduler for one in-order pipeline shared by two
// security domains. Every domain period is RUN (SLOT_CYCLES) + DRAIN
// (NSTAGES) + SWITCH (1 cycle), independent of requests, stalls or enables,
// so neither domain can observe the other through slot timing.
module pipe_domain_sched #(
   parameter int SLOT_CYCLES = 64,   // issue cycles per slot, >= 1
   parameter int NSTAGES     = 5,    // pipeline depth = drain length, >= 1
   parameter int CNT_W       = $clog2((SLOT_CYCLES > NSTAGES) ? SLOT_CYCLES : NSTAGES) + 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pipe_domain_sched_if.master    bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] SLOT_LOAD  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(NSTAGES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           r_state;
   logic             r_domain;
   logic [CNT_W-1:0] r_cnt;

   state_t           w_next_state;
   logic             w_next_domain;
   logic [CNT_W-1:0] w_next_cnt;
   logic [1:0]       w_grant;

   // State, domain and slot counter registers; reset lands in RUN of domain 0.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_RUN;
         r_domain <= 1'b0;
         r_cnt    <= SLOT_LOAD;
      end else begin
         r_state  <= w_next_state;
         r_domain <= w_next_domain;
         r_cnt    <= w_next_cnt;
      end
   end

   // Next-state logic: the counter alone decides when each phase ends, and
   // is reloaded on the cycle it reaches zero so it never wraps.
   // NOTE: every variable gets a default before the case so no path through
   // this block leaves one unassigned, which would infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_next_domain = r_domain;
      w_next_cnt    = r_cnt - CNT_ONE;
      unique case (r_state)
         ST_RUN: begin
            if (r_cnt == '0) begin
               w_next_state = ST_DRAIN;
               w_next_cnt   = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (r_cnt == '0) begin
               w_next_state = ST_SWITCH;
               w_next_cnt   = '0;
            end
         end
         ST_SWITCH: begin
            // The other domain's enable is only looked at here, so changes
            // elsewhere in the period have no effect until this cycle.
            w_next_state = ST_RUN;
            w_next_cnt   = SLOT_LOAD;
            if (bus.dom_en[~r_domain]) begin
               w_next_domain = ~r_domain;
            end
         end
         default: begin
            w_next_state = ST_RUN;
            w_next_cnt   = SLOT_LOAD;
         end
      endcase
   end

   // Zero-latency issue grant for the current domain only; the other domain's
   // request and enable bits never reach this path. Held off during reset.
   always_comb begin
      w_grant = 2'b00;
      if (reset_n && (r_state == ST_RUN)) begin
         w_grant[r_domain] = bus.dom_en[r_domain] & bus.req_val[r_domain] & ~bus.head_stall;
      end
   end

   assign bus.grant    = w_grant;
   assign bus.domain   = r_domain;
   assign bus.drain    = (r_state == ST_DRAIN);
   assign bus.flush    = (r_state == ST_SWITCH);
   assign bus.slot_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_domain_sched.sv
// Self-checking bench for pipe_domain_sched with SLOT_CYCLES=4, NSTAGES=2
// (period 7). A cycle-indexed reference model feeds a scoreboard queue;
// the reset-release sequence is also checked against a literal vector table.
module tb_pipe_domain_sched;

   localparam int SLOT   = 4;
   localparam int NST    = 2;
   localparam int PERIOD = SLOT + NST + 1;
   localparam int CNT_W  = $clog2((SLOT > NST) ? SLOT : NST) + 1;

   typedef struct {
      logic [1:0]       grant;
      logic             dom;
      logic             drain;
      logic             flush;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   typedef struct {
      logic [1:0] en;
      logic [1:0] rv;
      logic       hs;
      exp_t       e;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   flush_seen = 0;
   int   dom1_flush = 0;

   exp_t sb[$];
   vec_t tbl[8];

   int   m_p;
   logic m_dom;

   pipe_domain_sched_if #(.CNT_W(CNT_W)) bus ();

   pipe_domain_sched #(
      .SLOT_CYCLES (SLOT),
      .NSTAGES     (NST),
      .CNT_W       (CNT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      check({tag, ".grant"},    32'(bus.grant),    32'(e.grant));
      check({tag, ".domain"},   32'(bus.domain),   32'(e.dom));
      check({tag, ".drain"},    32'(bus.drain),    32'(e.drain));
      check({tag, ".flush"},    32'(bus.flush),    32'(e.flush));
      check({tag, ".slot_cnt"}, 32'(bus.slot_cnt), 32'(e.cnt));
   endtask

   // Reference: position within the period decides the phase.
   function automatic exp_t model_exp(input logic [1:0] en, input logic [1:0] rv, input logic hs);
      exp_t e;
      e.grant = 2'b00;
      e.dom   = m_dom;
      e.drain = 1'b0;
      e.flush = 1'b0;
      if (m_p < SLOT) begin
         e.cnt = CNT_W'(SLOT - 1 - m_p);
         if (en[m_dom] && rv[m_dom] && !hs) e.grant[m_dom] = 1'b1;
      end else if (m_p < SLOT + NST) begin
         e.drain = 1'b1;
         e.cnt   = CNT_W'(SLOT + NST - 1 - m_p);
      end else begin
         e.flush = 1'b1;
         e.cnt   = '0;
      end
      return e;
   endfunction

   task automatic model_adv(input logic [1:0] en);
      if (m_p == PERIOD - 1) begin
         if (en[~m_dom]) m_dom = ~m_dom;
         m_p = 0;
      end else begin
         m_p++;
      end
   endtask

   // Called just after a negedge: drive, compare half a cycle before the
   // next posedge, advance the model, wait for the following negedge.
   task automatic step(input logic [1:0] en, input logic [1:0] rv, input logic hs, input string tag);
      exp_t e;
      bus.dom_en     = en;
      bus.req_val    = rv;
      bus.head_stall = hs;
      sb.push_back(model_exp(en, rv, hs));
      #1;
      e = sb.pop_front();
      compare_all($sformatf("%s[p%0d]", tag, m_p), e);
      if (bus.flush) begin
         flush_seen++;
         if (bus.domain) dom1_flush++;
      end
      model_adv(en);
      @(negedge clk);
   endtask

   // Drops reset between edges, checks the asynchronous reset values before
   // any clock edge, then releases on a negedge and resets the model.
   task automatic do_reset(input string tag);
      exp_t r;
      r.grant = 2'b00; r.dom = 1'b0; r.drain = 1'b0; r.flush = 1'b0;
      r.cnt   = CNT_W'(SLOT - 1);
      bus.dom_en     = 2'b11;
      bus.req_val    = 2'b11;
      bus.head_stall = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      compare_all({tag, ".async"}, r);
      @(negedge clk);
      compare_all({tag, ".held"}, r);
      @(negedge clk);
      reset_n = 1'b1;
      m_p   = 0;
      m_dom = 1'b0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.dom_en     = tbl[i].en;
         bus.req_val    = tbl[i].rv;
         bus.head_stall = tbl[i].hs;
         #1;
         compare_all($sformatf("%s[c%0d]", tag, i), tbl[i].e);
         model_adv(tbl[i].en);
         @(negedge clk);
      end
   endtask

   initial begin
      // Reset-release sequence: {en, rv, hs, {grant, dom, drain, flush, cnt}}
      tbl[0] = '{2'b11, 2'b11, 1'b0, '{2'b01, 1'b0, 1'b0, 1'b0, CNT_W'(3)}};
      tbl[1] = '{2'b11, 2'b11, 1'b0, '{2'b01, 1'b0, 1'b0, 1'b0, CNT_W'(2)}};
      tbl[2] = '{2'b11, 2'b11, 1'b0, '{2'b01, 1'b0, 1'b0, 1'b0, CNT_W'(1)}};
      tbl[3] = '{2'b11, 2'b11, 1'b0, '{2'b01, 1'b0, 1'b0, 1'b0, CNT_W'(0)}};
      tbl[4] = '{2'b11, 2'b11, 1'b0, '{2'b00, 1'b0, 1'b1, 1'b0, CNT_W'(1)}};
      tbl[5] = '{2'b11, 2'b11, 1'b0, '{2'b00, 1'b0, 1'b1, 1'b0, CNT_W'(0)}};
      tbl[6] = '{2'b11, 2'b11, 1'b0, '{2'b00, 1'b0, 1'b0, 1'b1, CNT_W'(0)}};
      tbl[7] = '{2'b11, 2'b11, 1'b0, '{2'b10, 1'b1, 1'b0, 1'b0, CNT_W'(3)}};

      bus.dom_en = 2'b11; bus.req_val = 2'b11; bus.head_stall = 1'b0;
      m_p = 0; m_dom = 1'b0;
      @(negedge clk);

      // 1: reset values and the first period after release
      do_reset("t1");
      run_table("t1");

      // 2: random requests and stalls; period and alternation hold
      do_reset("t2");
      flush_seen = 0; dom1_flush = 0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
         step(2'b11, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "t2");
      end
      check("t2.flush_count", 32'(flush_seen), 32'd4);
      check("t2.dom1_flushes", 32'(dom1_flush), 32'd2);

      // 3: only domain 0 enabled; domain never leaves 0
      do_reset("t3");
      flush_seen = 0; dom1_flush = 0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         step(2'b01, 2'b11, 1'b0, "t3");
      end
      check("t3.flush_count", 32'(flush_seen), 32'd3);
      check("t3.dom1_flushes", 32'(dom1_flush), 32'd0);

      // 3b: both domains disabled; schedule keeps cycling, no grants
      do_reset("t3b");
      for (int i = 0; i < PERIOD + 2; i++) begin
         step(2'b00, 2'b11, 1'b0, "t3b");
      end

      // 4: stall held across domain 0's whole RUN, released afterwards
      do_reset("t4");
      for (int i = 0; i < 2 * PERIOD; i++) begin
         step(2'b11, 2'b11, (i < SLOT) ? 1'b1 : 1'b0, "t4");
      end

      // 5: async reset in the middle of DRAIN, then identical restart
      do_reset("t5");
      for (int i = 0; i < SLOT + 1; i++) begin
         step(2'b11, 2'b11, 1'b0, "t5.pre");
      end
      do_reset("t5.mid");
      run_table("t5.after");

      // 6: the idle domain's request/enable toggle during the other's RUN
      do_reset("t6");
      for (int i = 0; i < 3 * PERIOD; i++) begin
         logic [1:0] en;
         logic [1:0] rv;
         en = 2'b11;
         rv = 2'b11;
         if (m_p < SLOT) begin
            if (m_dom == 1'b0) begin
               en[1] = 1'($urandom_range(0, 1));
               rv[1] = 1'($urandom_range(0, 1));
            end else begin
               en[0] = 1'($urandom_range(0, 1));
               rv[0] = 1'($urandom_range(0, 1));
            end
         end
         step(en, rv, 1'b0, "t6");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
